// File: rtl/comp_serial_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   stateT  : FSM state encoding (idle, running, result presented)
//   resultT : encoding of the internal gt/lt/eq result register;
//             RES_NONE means "no decision yet" and drives all flags low
package comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } stateT;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_GT   = 2'd1,
        RES_LT   = 2'd2,
        RES_EQ   = 2'd3
    } resultT;

endpackage

// File: rtl/comp_serial_if.sv
// Request/result bundle of the serial comparator.
//   iStart/iSigned/iA/iB : request side, driven by the master
//   oBusy/oDone          : handshake status, driven by the slave
//   oAgtB/oAltB/oAeqB    : one-hot result flags
//   oCycles              : digits examined for the last result
interface comp_serial_if #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) ();
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    logic             iStart;
    logic             iSigned;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             oBusy;
    logic             oDone;
    logic             oAgtB;
    logic             oAltB;
    logic             oAeqB;
    logic [CW-1:0]    oCycles;

    modport master (
        output iStart, iSigned, iA, iB,
        input  oBusy, oDone, oAgtB, oAltB, oAeqB, oCycles
    );

    modport slave (
        input  iStart, iSigned, iA, iB,
        output oBusy, oDone, oAgtB, oAltB, oAeqB, oCycles
    );
endinterface

// File: rtl/comp_serial_digit.sv
// Combinational unsigned compare of one DIGIT-bit digit.
//   iA, iB : digit of each operand
//   oGt    : iA > iB
//   oLt    : iA < iB
module comp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] iA,
    input  logic [DIGIT-1:0] iB,
    output logic             oGt,
    output logic             oLt
);
    assign oGt = (iA > iB);
    assign oLt = (iA < iB);
endmodule

// File: rtl/comp_serial.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands MSB-first,
// DIGIT bits per clock, unsigned or two's-complement, with optional early exit.
//   iClk, iRsn : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of comp_serial_if (start/busy/done handshake,
//                operands, one-hot result flags, digit count)
module comp_serial
    import comp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input logic          iClk,
    input logic          iRsn,
    comp_serial_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CW-1:0]    LAST_IDX = CW'(NDIG - 1);

    stateT            state;
    logic [WIDTH-1:0] shA;
    logic [WIDTH-1:0] shB;
    logic [CW-1:0]    digCnt;
    logic [CW-1:0]    cycles;
    resultT           recRes;    // first unequal digit seen so far (hidden while busy)
    resultT           res;       // published result
    logic             busy;
    logic             done;

    logic             dGt;
    logic             dLt;
    resultT           digRes;
    logic             decide;

    comp_digit #(
        .DIGIT (DIGIT)
    ) uDigit (
        .iA  (shA[WIDTH-1 -: DIGIT]),
        .iB  (shB[WIDTH-1 -: DIGIT]),
        .oGt (dGt),
        .oLt (dLt)
    );

    // Keep the earliest unequal digit; later digits cannot change the ordering.
    always_comb begin
        digRes = recRes;
        if (recRes == RES_NONE) begin
            if (dGt) begin
                digRes = RES_GT;
            end else if (dLt) begin
                digRes = RES_LT;
            end
        end
        decide = (EARLY_EXIT && (dGt || dLt)) || (digCnt == LAST_IDX);
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state  <= ST_IDLE;
            shA    <= '0;
            shB    <= '0;
            digCnt <= '0;
            cycles <= '0;
            recRes <= RES_NONE;
            res    <= RES_NONE;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (bus.iStart) begin
                        // Flipping the sign bit maps two's complement onto offset
                        // binary, so the unsigned digit compare orders correctly.
                        shA    <= bus.iA ^ (bus.iSigned ? MSB_MASK : '0);
                        shB    <= bus.iB ^ (bus.iSigned ? MSB_MASK : '0);
                        digCnt <= '0;
                        cycles <= '0;
                        recRes <= RES_NONE;
                        res    <= RES_NONE;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    shA    <= shA << DIGIT;
                    shB    <= shB << DIGIT;
                    digCnt <= digCnt + CW'(1);
                    recRes <= digRes;
                    if (decide) begin
                        res    <= (digRes == RES_NONE) ? RES_EQ : digRes;
                        cycles <= digCnt + CW'(1);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.oBusy   = busy;
    assign bus.oDone   = done;
    assign bus.oAgtB   = (res == RES_GT);
    assign bus.oAltB   = (res == RES_LT);
    assign bus.oAeqB   = (res == RES_EQ);
    assign bus.oCycles = cycles;
endmodule

// File: tb/tb_comp_serial.sv
// Bench for comp_serial: two instances (early exit on/off) share one stimulus
// stream; each has its own expected-result queue and monitor.
module tb_comp_serial;

    localparam int W = 16;
    localparam int D = 4;

    typedef struct {
        int r;       // 1 gt, 2 lt, 3 eq
        int cycles;
        int acc;     // cycle number of the accept edge
    } expT;

    logic        clk = 1'b0;
    logic        rsn = 1'b0;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    expT         qE[$];
    expT         qF[$];

    comp_serial_if #(.WIDTH(W), .DIGIT(D)) ifE ();
    comp_serial_if #(.WIDTH(W), .DIGIT(D)) ifF ();

    assign ifE.iStart  = start;
    assign ifE.iSigned = sgn;
    assign ifE.iA      = opA;
    assign ifE.iB      = opB;
    assign ifF.iStart  = start;
    assign ifF.iSigned = sgn;
    assign ifF.iA      = opA;
    assign ifF.iB      = opB;

    comp_serial #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1'b1)) dutE (
        .iClk (clk),
        .iRsn (rsn),
        .bus  (ifE.slave)
    );

    comp_serial #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1'b0)) dutF (
        .iClk (clk),
        .iRsn (rsn),
        .bus  (ifF.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int flagsOf(input int r);
        return (r == 1) ? 4 : (r == 2) ? 2 : 1;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        expT e;
        if (ifE.oBusy)
            chk("E flags low while busy", {ifE.oAgtB, ifE.oAltB, ifE.oAeqB}, 0);
        if (ifE.oDone) begin
            if (qE.size() == 0) begin
                chk("E unexpected oDone", 1, 0);
            end else begin
                e = qE.pop_front();
                chk("E flags", {ifE.oAgtB, ifE.oAltB, ifE.oAeqB}, flagsOf(e.r));
                chk("E oCycles", ifE.oCycles, e.cycles);
                chk("E latency", cyc - e.acc, e.cycles);
                chk("E busy low at done", ifE.oBusy, 0);
            end
        end
    end

    always @(negedge clk) begin
        expT e;
        if (ifF.oBusy)
            chk("F flags low while busy", {ifF.oAgtB, ifF.oAltB, ifF.oAeqB}, 0);
        if (ifF.oDone) begin
            if (qF.size() == 0) begin
                chk("F unexpected oDone", 1, 0);
            end else begin
                e = qF.pop_front();
                chk("F flags", {ifF.oAgtB, ifF.oAltB, ifF.oAeqB}, flagsOf(e.r));
                chk("F oCycles", ifF.oCycles, e.cycles);
                chk("F latency", cyc - e.acc, e.cycles);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a falling edge; start is high across the next rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int r, input int cycE);
        expT e;
        start = 1'b1;
        opA   = a;
        opB   = b;
        sgn   = s;
        e.r = r;
        e.acc = cyc + 1;
        e.cycles = cycE;
        qE.push_back(e);
        e.cycles = 4;
        qF.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitBoth();
        int n = 0;
        while ((ifE.oBusy || ifF.oBusy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (ifE.oBusy || ifF.oBusy) chk("busy timeout", 1, 0);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input int r, input int cycE);
        issue(a, b, s, r, cycE);
        waitBoth();
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string name);
        chk({name, " E outputs"}, {ifE.oBusy, ifE.oDone, ifE.oAgtB, ifE.oAltB,
                                    ifE.oAeqB, ifE.oCycles}, 0);
        chk({name, " F outputs"}, {ifF.oBusy, ifF.oDone, ifF.oAgtB, ifF.oAltB,
                                    ifF.oAeqB, ifF.oCycles}, 0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] d;
        int           r;
        int           cE;

        #1 checkAllZero("reset");
        repeat (2) @(negedge clk);
        rsn = 1'b1;
        @(negedge clk);
        checkAllZero("post reset idle");

        // Directed vectors: r (1 gt, 2 lt, 3 eq) and early-exit digit count by hand.
        run(16'h1234, 16'h1234, 1'b0, 3, 4);
        run(16'hA000, 16'h9FFF, 1'b0, 1, 1);
        run(16'h8000, 16'h0001, 1'b1, 2, 1);
        run(16'h8000, 16'h0001, 1'b0, 1, 1);
        run(16'hFFFF, 16'hFFFE, 1'b1, 1, 4);
        run(16'h1234, 16'h1244, 1'b0, 2, 3);
        run(16'h7FFF, 16'h8000, 1'b1, 1, 1);
        run(16'hFFFF, 16'h0000, 1'b1, 2, 1);
        run(16'h0F00, 16'h0E00, 1'b0, 1, 2);
        run(16'h0000, 16'h0000, 1'b1, 3, 4);

        // Start pulse while busy must be ignored.
        issue(16'h1234, 16'h1234, 1'b0, 3, 4);
        start = 1'b1;
        opA = 16'h0000;
        opB = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        opA = 16'hFFFF;
        waitBoth();

        // Back-to-back: start in the oDone cycle.
        @(negedge clk);
        issue(16'h5555, 16'h5555, 1'b0, 3, 4);
        waitBoth();
        chk("b2b done visible E", ifE.oDone, 1);
        chk("b2b done visible F", ifF.oDone, 1);
        issue(16'h0001, 16'h0002, 1'b0, 2, 4);
        waitBoth();
        @(negedge clk);

        // Reset in the middle of RUN: no result may appear.
        start = 1'b1;
        opA = 16'h1234;
        opB = 16'h1233;
        sgn = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rsn = 1'b0;
        #1 checkAllZero("mid-run reset");
        @(negedge clk);
        rsn = 1'b1;
        repeat (6) @(negedge clk);
        checkAllZero("after abort");
        run(16'h0003, 16'h0004, 1'b0, 2, 4);

        // Random pairs against a behavioural compare.
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (W'(1) << $urandom_range(0, W - 1));
                default: b = W'($urandom);
            endcase
            s = 1'($urandom_range(0, 1));
            if (s) r = ($signed(a) > $signed(b)) ? 1 : ($signed(a) < $signed(b)) ? 2 : 3;
            else   r = (a > b) ? 1 : (a < b) ? 2 : 3;
            d = a ^ b;
            cE = 0;
            for (int j = 0; j < 4; j++) begin
                if (cE == 0 && d[W-1-4*j -: 4] != 4'h0) cE = j + 1;
            end
            if (cE == 0) cE = 4;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(a, b, s, r, cE);
            waitBoth();
        end

        repeat (4) @(negedge clk);
        chk("E queue drained", qE.size(), 0);
        chk("F queue drained", qF.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
